// File: rtl/target_seq_gen.sv
// Paced 8-step target-bit transmitter for the Precision Button Press game, with a saturating win score.
// Optional `TSG_RANDOM_EN: each round's pattern is taken from a free-running LFSR instead of SEED.
module target_seq_gen #(
    parameter int         TICK_DIV = 100_000_000,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       WIN,
    output logic       Y,
    output logic       STEP,
    output logic [2:0] IDX,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] SCORE
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    pat_q, pat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          y_q, y_d;
    logic          step_q, step_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          win_q;
    logic          won_q;
    logic [7:0]    score_q;
    logic [7:0]    cap_s;
    logic          tick_wrap_s;
    logic [2:0]    idx_nxt_s;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

`ifdef TSG_RANDOM_EN
    logic [7:0] lfsr_q;

    // Free-running Galois LFSR; never reaches zero from a nonzero seed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign cap_s = lfsr_q;
`else
    assign cap_s = SEED;
`endif

    assign tick_wrap_s = (cnt_q == CNT_MAX);
    assign idx_nxt_s   = idx_q + 3'd1;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (tick_wrap_s && (idx_q == 3'd7)) state_d = S_FIN;
                else                                state_d = S_RUN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered so they line up with the new state
    always_comb begin
        pat_d  = pat_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        y_d    = 1'b0;
        step_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    pat_d  = cap_s;
                    cnt_d  = '0;
                    idx_d  = 3'd0;
                    y_d    = cap_s[0];
                    step_d = 1'b1;
                    busy_d = 1'b1;
                end else begin
                    pat_d = pat_q;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                y_d    = pat_q[idx_q];
                if (tick_wrap_s) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        y_d    = 1'b0;
                    end else begin
                        idx_d  = idx_nxt_s;
                        step_d = 1'b1;
                        y_d    = pat_q[idx_nxt_s];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                done_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pat_q  <= 8'h00;
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            y_q    <= 1'b0;
            step_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            y_q    <= y_d;
            step_q <= step_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Win capture is qualified by the state at sampling time, so a WIN coinciding with START in IDLE is dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            win_q   <= 1'b0;
            won_q   <= 1'b0;
            score_q <= 8'h00;
        end else begin
            win_q <= WIN && (state_q != S_IDLE);
            if ((state_q == S_IDLE) && START) begin
                won_q <= 1'b0;
            end else if (win_q) begin
                won_q <= 1'b1;
            end else begin
                won_q <= won_q;
            end
            if (win_q && !won_q && (score_q != 8'hFF)) begin
                score_q <= score_q + 8'd1;
            end else begin
                score_q <= score_q;
            end
        end
    end

    assign Y     = y_q;
    assign STEP  = step_q;
    assign IDX   = idx_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign SCORE = score_q;

endmodule

// File: tb/tb_target_seq_gen.sv
// Directed bench for target_seq_gen with TICK_DIV=4 (2 when TSG_RANDOM_EN is defined) and SEED=8'hA5.
module tb_target_seq_gen;

`ifdef TSG_RANDOM_EN
    localparam int TD = 2;
`else
    localparam int TD = 4;
`endif
    localparam logic [7:0] SEED_P = 8'hA5;
    localparam int RL = 8 * TD;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       WIN = 1'b0;
    logic       Y, STEP, BUSY, DONE;
    logic [2:0] IDX;
    logic [7:0] SCORE;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_score = 0;
    logic [7:0] m_lfsr;

    target_seq_gen #(.TICK_DIV(TD), .SEED(SEED_P)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .WIN(WIN),
        .Y(Y), .STEP(STEP), .IDX(IDX), .BUSY(BUSY), .DONE(DONE), .SCORE(SCORE)
    );

    always #5 CLK = ~CLK;

    // Reference LFSR: same polynomial, same reset
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) m_lfsr <= SEED_P;
        else        m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end

    // Starts a round from IDLE and returns at the negedge of cycle RL+2 (IDLE); WIN pulses on listed cycles
    task automatic do_round(input int w1, input int w2, input int w3, input bit ws);
        START = 1'b1; WIN = ws;
        @(negedge CLK);
        START = 1'b0; WIN = 1'b0;
        for (int c = 0; c <= RL + 1; c++) begin
            WIN = (c == w1) || (c == w2) || (c == w3);
            @(negedge CLK);
        end
        WIN = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((BUSY || DONE) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        vec_cnt++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            err_cnt++;
            $display("FAIL wait_idle: busy=%b done=%b after %0d cycles, required idle", BUSY, DONE, n);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic exp_y0;
        #3;
        vec_cnt++;
        if ({Y, STEP, IDX, BUSY, DONE, SCORE} !== 15'h0000) begin
            err_cnt++;
            $display("FAIL reset_vals: got %h required 0000", {Y, STEP, IDX, BUSY, DONE, SCORE});
        end
        @(negedge CLK); RST_N = 1'b1; @(negedge CLK);
        START = 1'b1; @(negedge CLK); START = 1'b0;
        for (int c = 0; c < 10; c++) begin
            WIN = (c == 2);
            @(negedge CLK);
        end
        WIN = 1'b0;
        vec_cnt++;
        if (SCORE !== 8'd1 || BUSY !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset_score: score=%0d busy=%b required 1/1", SCORE, BUSY);
        end
        #2 RST_N = 1'b0;
        #1;
        vec_cnt++;
        if ({Y, STEP, IDX, BUSY, DONE, SCORE} !== 15'h0000) begin
            err_cnt++;
            $display("FAIL midrun_reset: got %h required 0000", {Y, STEP, IDX, BUSY, DONE, SCORE});
        end
        @(negedge CLK); @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        exp_y0 = m_lfsr[0];
`ifndef TSG_RANDOM_EN
        exp_y0 = SEED_P[0];
`endif
        START = 1'b1; @(negedge CLK); START = 1'b0;
        vec_cnt++;
        if (STEP !== 1'b1 || BUSY !== 1'b1 || IDX !== 3'd0 || Y !== exp_y0 || SCORE !== 8'd0 || DONE !== 1'b0) begin
            err_cnt++;
            $display("FAIL fresh_round: step=%b busy=%b idx=%0d y=%b score=%0d done=%b required 1/1/0/%b/0/0",
                     STEP, BUSY, IDX, Y, SCORE, DONE, exp_y0);
        end
        wait_idle();
    endtask

`ifndef TSG_RANDOM_EN
    task automatic test_fixed_pattern();
        logic [7:0] pat;
        int k;
        pat = 8'hA5;
        START = 1'b1; @(negedge CLK); START = 1'b0;
        for (int c = 0; c <= RL + 1; c++) begin
            k = c / TD;
            vec_cnt++;
            if (c < RL) begin
                if (BUSY !== 1'b1 || DONE !== 1'b0 || Y !== pat[k] || IDX !== 3'(k) || STEP !== (c % TD == 0)) begin
                    err_cnt++;
                    $display("FAIL fixed_step c=%0d: busy=%b done=%b y=%b idx=%0d step=%b required 1/0/%b/%0d/%b",
                             c, BUSY, DONE, Y, IDX, STEP, pat[k], k, (c % TD == 0));
                end
            end else if (c == RL) begin
                if (DONE !== 1'b1 || BUSY !== 1'b0 || Y !== 1'b0 || STEP !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL fixed_done: done=%b busy=%b y=%b step=%b required 1/0/0/0", DONE, BUSY, Y, STEP);
                end
            end else begin
                if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL fixed_idle: done=%b busy=%b required 0/0", DONE, BUSY);
                end
            end
            @(negedge CLK);
        end
    endtask
`endif

    task automatic test_win();
        do_round(3, 10, RL, 1'b0);
        @(negedge CLK); @(negedge CLK);
        vec_cnt++;
        if (SCORE !== 8'd1) begin
            err_cnt++;
            $display("FAIL win_once: score=%0d required 1", SCORE);
        end
        do_round(RL, -1, -1, 1'b0);
        @(negedge CLK); @(negedge CLK);
        vec_cnt++;
        if (SCORE !== 8'd2) begin
            err_cnt++;
            $display("FAIL win_in_done: score=%0d required 2", SCORE);
        end
        WIN = 1'b1; @(negedge CLK); WIN = 1'b0;
        repeat (4) @(negedge CLK);
        vec_cnt++;
        if (SCORE !== 8'd2) begin
            err_cnt++;
            $display("FAIL win_idle: score=%0d required 2", SCORE);
        end
        do_round(-1, -1, -1, 1'b1);
        @(negedge CLK); @(negedge CLK);
        vec_cnt++;
        if (SCORE !== 8'd2) begin
            err_cnt++;
            $display("FAIL win_with_start: score=%0d required 2", SCORE);
        end
        exp_score = 2;
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 256; r++) begin
            do_round(5, -1, -1, 1'b0);
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
            vec_cnt++;
            if (SCORE !== 8'(exp_score)) begin
                err_cnt++;
                $display("FAIL saturate r=%0d: score=%0d required %0d", r, SCORE, exp_score);
            end
        end
    endtask

    task automatic test_start_held();
        START = 1'b1;
        @(negedge CLK);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c <= RL + 1; c++) begin
                vec_cnt++;
                if (c < RL) begin
                    if (BUSY !== 1'b1 || DONE !== 1'b0 || IDX !== 3'(c / TD)) begin
                        err_cnt++;
                        $display("FAIL held_run r=%0d c=%0d: busy=%b done=%b idx=%0d required 1/0/%0d",
                                 r, c, BUSY, DONE, IDX, c / TD);
                    end
                end else if (c == RL) begin
                    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
                        err_cnt++;
                        $display("FAIL held_done r=%0d: done=%b busy=%b required 1/0", r, DONE, BUSY);
                    end
                end else begin
                    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                        err_cnt++;
                        $display("FAIL held_gap r=%0d: done=%b busy=%b required 0/0", r, DONE, BUSY);
                    end
                    if (r == 2) START = 1'b0;
                end
                @(negedge CLK);
            end
        end
        vec_cnt++;
        if (BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL held_release: busy=%b required 0", BUSY);
        end
    endtask

`ifdef TSG_RANDOM_EN
    task automatic test_random();
        logic [7:0] pat;
        for (int r = 0; r < 10; r++) begin
            repeat ((r * 3) % 7) @(negedge CLK);
            pat = m_lfsr;
            START = 1'b1; @(negedge CLK); START = 1'b0;
            for (int c = 0; c < RL; c++) begin
                if (c % TD == TD - 1) begin
                    vec_cnt++;
                    if (Y !== pat[c / TD]) begin
                        err_cnt++;
                        $display("FAIL random r=%0d bit=%0d: y=%b required %b (pat %h)", r, c / TD, Y, pat[c / TD], pat);
                    end
                end
                @(negedge CLK);
            end
            wait_idle();
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef TSG_RANDOM_EN
        test_fixed_pattern();
`endif
        test_win();
        test_saturation();
        test_start_held();
`ifdef TSG_RANDOM_EN
        test_random();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/target_seq_gen.md
# target_seq_gen

Target-pattern transmitter for the Precision Button Press game. It produces the paced target bit `Y` that the player must track with the button `X`. The downstream consecutive-match checker compares `X` against `Y` every clock and pulses its success output, which feeds back into this block's `WIN` input. The block sequences one 8-step round per `START`, paces each step with a tick divider, and keeps a saturating win score for display.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per target step. Legal range ≥ 2.
- `SEED`, default 8'hA5: LFSR reset value and the fixed pattern. Must be nonzero.

Ports:
- `CLK` in 1: single system clock; all logic is on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: round request; sampled only in IDLE.
- `WIN` in 1: success pulse from the match checker.
- `Y` out 1: current target bit.
- `STEP` out 1: one-cycle pulse marking each new target bit.
- `IDX` out 3: current step index, 0..7.
- `BUSY` out 1: high while a round runs.
- `DONE` out 1: one-cycle end-of-round pulse.
- `SCORE` out 8: rounds won, saturating.

## Operation
- States:
  - IDLE: `Y`=0, `BUSY`=0. `START`=1 captures the pattern into `PAT[7:0]` and moves to RUN.
  - RUN: `BUSY`=1, `Y`=`PAT[IDX]`. Bits are sent LSB first.
  - FIN: lasts one cycle. `DONE`=1, `BUSY`=0, `Y`=0. Always returns to IDLE.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Next value = {0, L[7:1]} ^ (L[0] ? 8'hB8 : 0).
  - Free-runs every cycle in all states.
  - Resets to `SEED` and never reaches zero.
- Tick counter, width $clog2(TICK_DIV):
  - Cleared on entry to RUN.
  - Counts 0..TICK_DIV-1 and wraps.
  - On wrap with `IDX`<7: `IDX` increments and `STEP` pulses on the following cycle.
  - On wrap with `IDX`=7: state goes to FIN.
- Win scoring:
  - `WIN`=1 in RUN or FIN counts once per round, tracked by a `won` flag that is cleared on entry to RUN.
  - A counted win increments `SCORE`, which saturates at 255.
  - `WIN` in IDLE is ignored. Repeated `WIN` within the same round is ignored.
- `START` in RUN or FIN is ignored. There is no queuing.
- Simultaneous `START` and `WIN` in IDLE: the round starts and the `WIN` is dropped.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `Y`=0, `STEP`=0, `IDX`=0, `BUSY`=0, `DONE`=0, `SCORE`=0, LFSR=`SEED`, `PAT`=0, `won`=0.
- Reset asserted mid-round aborts the round with no `DONE` pulse and clears `SCORE`.
- Round start:
  - `START` is high at edge T in IDLE.
  - From cycle T+1: `BUSY`=1, `IDX`=0, `Y`=`PAT[0]`, `STEP`=1 for that one cycle.
- Step spacing: step k (k = 0..7) begins at cycle T+1+k·TICK_DIV, where `STEP` pulses and `Y`/`IDX` update.
- `BUSY` stays high for exactly 8·TICK_DIV cycles.
- `DONE` is high in cycle T+1+8·TICK_DIV. The earliest accepted next `START` is the edge ending the following cycle.
- `WIN` is registered: `SCORE` updates one cycle after the `WIN` sample.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `TSG_RANDOM_EN` defined: on `START`, `PAT` takes the current LFSR value, giving a new pattern each round.
- `TSG_RANDOM_EN` undefined: `PAT` always takes `SEED` (practice mode with the same pattern every round). The LFSR may be optimized away. All other behaviour is identical.

## Test plan
- Reset check: hold `RST_N`=0 mid-RUN, then release. All outputs read 0, the next `START` begins a fresh round, and `SCORE`=0.
- Fixed pattern (`TICK_DIV`=4, `TSG_RANDOM_EN` undefined, `SEED`=8'hA5): pulse `START`.
  - `Y` reads 1,0,1,0,0,1,0,1 with each bit held 4 cycles.
  - `STEP` pulses 8 times, 4 cycles apart.
  - `BUSY` is high for 32 cycles, then `DONE` pulses for 1 cycle.
- Win counting: pulse `WIN` three times in one round, including once during the `DONE` cycle. `SCORE` goes 0→1 only. `WIN` in IDLE leaves `SCORE` at 1.
- Saturation: run 256 rounds, each with one `WIN`. `SCORE` ends at 255.
- `START` ignored: hold `START`=1 continuously.
  - Rounds run back-to-back, each 32 `BUSY` cycles.
  - `DONE` and one IDLE cycle separate consecutive rounds.
  - A `START` pulse mid-RUN does not restart `IDX`.
- Random mode (`TSG_RANDOM_EN` defined, `TICK_DIV`=2): the bench LFSR model predicts `PAT` at each `START` edge. Sampled `Y` matches the predicted bits LSB first across 10 rounds started at varied times.
